// File: rtl/alu_regfile_pipe_if.sv
// Command/result handshake bundle for alu_regfile_pipe.
// master: command source + result sink; slave: the ALU block.
interface alu_regfile_pipe_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [AW-1:0]    addr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;

  modport master (
    output in_valid, opcode, a, b, addr,
    output out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, opcode, a, b, addr,
    input  out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/alu_regfile_pipe.sv
// WIDTH-bit ALU + 2**AW regfile, valid/ready in and out.
// Ports: clk, rst_n (async low), bus (slave). ALU_MUL_EN adds MUL.
module alu_regfile_pipe #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_regfile_pipe_if.slave    bus
);
  localparam int SW    = $clog2(WIDTH);
  localparam int DEPTH = 1 << AW;
  localparam int MSB   = WIDTH - 1;

  logic [WIDTH-1:0] rf [DEPTH];

  logic             idle;
  logic             accept;
  logic             is_mul;
  logic             mul_done;
  logic [WIDTH-1:0] mul_r;
  logic             mul_c;

  logic [WIDTH-1:0] rf_rd;
  logic [WIDTH-1:0] op2;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_r;
  logic             alu_v;
  logic             alu_c;

  // Nothing may be accepted in reset, so gate with rst_n
  assign bus.in_ready = rst_n & idle &
                        (!bus.out_valid | bus.out_ready);
  assign accept = bus.in_valid & bus.in_ready;

`ifdef ALU_MUL_EN
  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [SW-1:0] LAST = SW'(WIDTH - 1);

  state_t             state_q;
  state_t             state_d;
  logic [SW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   mplier_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept && is_mul) state_d = BUSY;
      BUSY: if (cnt_q == LAST)    state_d = IDLE;
    endcase
  end

  assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (accept && is_mul) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, bus.a};
      mplier_q <= bus.b;
    end else if (state_q == BUSY) begin
      cnt_q    <= cnt_q + 1'b1;
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end

  assign idle     = (state_q == IDLE);
  assign is_mul   = (bus.opcode == 4'hC);
  // Last shift-add step: final product is acc_d, not yet in acc_q
  assign mul_done = (state_q == BUSY) && (cnt_q == LAST);
  assign mul_r    = acc_d[WIDTH-1:0];
  assign mul_c    = |acc_d[2*WIDTH-1:WIDTH];
`else
  assign idle     = 1'b1;
  assign is_mul   = 1'b0;
  assign mul_done = 1'b0;
  assign mul_r    = '0;
  assign mul_c    = 1'b0;
`endif

  assign rf_rd = rf[bus.addr];
  assign op2   = (bus.opcode == 4'hA || bus.opcode == 4'hB)
               ? rf_rd : bus.b;

  always_comb begin
    sum   = '0;
    alu_r = '0;
    alu_v = 1'b0;
    alu_c = 1'b0;
    unique case (bus.opcode)
      4'h0, 4'hA: begin
        sum   = {1'b0, bus.a} + {1'b0, op2};
        alu_r = sum[MSB:0];
        alu_c = sum[WIDTH];
        alu_v = (bus.a[MSB] == op2[MSB]) &
                (alu_r[MSB] != bus.a[MSB]);
      end
      4'h1, 4'hB: begin
        sum   = {1'b0, bus.a} + {1'b0, ~op2} +
                (WIDTH+1)'(1);
        alu_r = sum[MSB:0];
        alu_c = sum[WIDTH];
        alu_v = (bus.a[MSB] != op2[MSB]) &
                (alu_r[MSB] != bus.a[MSB]);
      end
      4'h2: alu_r = bus.a & bus.b;
      4'h3: alu_r = bus.a | bus.b;
      4'h4: alu_r = bus.a ^ bus.b;
      4'h5: alu_r = bus.a << bus.b[SW-1:0];
      4'h6: alu_r = bus.a >> bus.b[SW-1:0];
      4'h7: alu_r = bus.b;
      4'h8: alu_r = bus.a;
      4'h9: alu_r = rf_rd;
      default: alu_r = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
    end else if (accept && bus.opcode == 4'h8) begin
      rf[bus.addr] <= bus.a;
    end
  end

  // in_ready implies idle, so accept and mul_done never coincide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      bus.flags     <= 4'b1000;
    end else if (accept && !is_mul) begin
      bus.out_valid <= 1'b1;
      bus.result    <= alu_r;
      bus.flags     <= {alu_r == '0, alu_r[MSB], alu_v, alu_c};
    end else if (mul_done) begin
      bus.out_valid <= 1'b1;
      bus.result    <= mul_r;
      bus.flags     <= {mul_r == '0, mul_r[MSB], 1'b0, mul_c};
    end else if (bus.out_valid && bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_regfile_pipe.sv
// Directed bench for alu_regfile_pipe (WIDTH=8, AW=3).
// Covers both builds via ALU_MUL_EN.
module tb_alu_regfile_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  alu_regfile_pipe_if #(.WIDTH(8), .AW(3)) bus ();

  alu_regfile_pipe #(.WIDTH(8), .AW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op,
                       input logic [7:0] a,
                       input logic [7:0] b,
                       input logic [2:0] ad);
    bus.in_valid = 1'b1;
    bus.opcode   = op;
    bus.a        = a;
    bus.b        = b;
    bus.addr     = ad;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic res(input string tag,
                     input logic [7:0] r,
                     input logic [3:0] f);
    chk({tag, "_v"}, 16'(bus.out_valid), 16'h1);
    chk({tag, "_r"}, 16'(bus.result), 16'(r));
    chk({tag, "_f"}, 16'(bus.flags), 16'(f));
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.opcode    = 4'h0;
    bus.a         = 8'h00;
    bus.b         = 8'h00;
    bus.addr      = 3'd0;
    bus.out_ready = 1'b1;

    step();
    step();
    chk("rst_ov",  16'(bus.out_valid), 16'h0);
    chk("rst_r",   16'(bus.result),    16'h0);
    chk("rst_f",   16'(bus.flags),     16'h8);
    chk("rst_rdy", 16'(bus.in_ready),  16'h0);
    rst_n = 1'b1;
    #1;
    chk("rdy_up",  16'(bus.in_ready),  16'h1);

    issue(4'h0, 8'h7F, 8'h01, 3'd0);
    res("add_ovf", 8'h80, 4'b0110);
    step();
    chk("pop_ov", 16'(bus.out_valid), 16'h0);

    issue(4'h1, 8'h00, 8'h01, 3'd0);
    res("sub_brw", 8'hFF, 4'b0100);
    issue(4'h1, 8'h05, 8'h05, 3'd0);
    res("sub_eq", 8'h00, 4'b1001);

    issue(4'h8, 8'h3C, 8'h00, 3'd5);
    res("reg_wr", 8'h3C, 4'b0000);
    issue(4'h9, 8'h00, 8'h00, 3'd5);
    res("reg_rd5", 8'h3C, 4'b0000);
    issue(4'hA, 8'h04, 8'h00, 3'd5);
    res("add_reg", 8'h40, 4'b0000);
    issue(4'h9, 8'h00, 8'h00, 3'd2);
    res("reg_rd2", 8'h00, 4'b1000);
    issue(4'hB, 8'h3C, 8'h00, 3'd5);
    res("sub_reg", 8'h00, 4'b1001);

    issue(4'h2, 8'hF0, 8'h3C, 3'd0);
    res("and", 8'h30, 4'b0000);
    issue(4'h3, 8'h0F, 8'hF0, 3'd0);
    res("or", 8'hFF, 4'b0100);
    issue(4'h4, 8'hFF, 8'hFF, 3'd0);
    res("xor", 8'h00, 4'b1000);
    issue(4'h5, 8'h01, 8'h0B, 3'd0);
    res("shl", 8'h08, 4'b0000);
    issue(4'h6, 8'h80, 8'h07, 3'd0);
    res("shr", 8'h01, 4'b0000);
    issue(4'h7, 8'h00, 8'hA5, 3'd0);
    res("pass_b", 8'hA5, 4'b0100);
    issue(4'hE, 8'h12, 8'h34, 3'd0);
    res("illegal", 8'h00, 4'b1000);
    step();

    bus.out_ready = 1'b0;
    issue(4'h0, 8'h01, 8'h01, 3'd0);
    res("bp_first", 8'h02, 4'b0000);
    bus.in_valid = 1'b1;
    bus.opcode   = 4'h0;
    bus.a        = 8'h03;
    bus.b        = 8'h04;
    #1;
    chk("bp_rdy0", 16'(bus.in_ready), 16'h0);
    step();
    res("bp_hold", 8'h02, 4'b0000);
    chk("bp_rdy1", 16'(bus.in_ready), 16'h0);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_rdy2", 16'(bus.in_ready), 16'h1);
    step();
    bus.in_valid = 1'b0;
    res("bp_second", 8'h07, 4'b0000);
    step();
    chk("bp_pop", 16'(bus.out_valid), 16'h0);

`ifdef ALU_MUL_EN
    issue(4'hC, 8'h10, 8'h11, 3'd0);
    for (int i = 0; i < 8; i++) begin
      chk("mul_rdy", 16'(bus.in_ready),  16'h0);
      chk("mul_ov",  16'(bus.out_valid), 16'h0);
      step();
    end
    res("mul", 8'h10, 4'b0001);
    chk("mul_rdy_end", 16'(bus.in_ready), 16'h1);
    step();

    issue(4'hC, 8'h03, 8'h05, 3'd0);
    repeat (2) step();
`else
    issue(4'hC, 8'h10, 8'h11, 3'd0);
    res("op_c_ill", 8'h00, 4'b1000);
    step();
    bus.out_ready = 1'b0;
    issue(4'h0, 8'h01, 8'h02, 3'd0);
    res("pend", 8'h03, 4'b0000);
`endif
    rst_n = 1'b0;
    #1;
    chk("mrst_ov",  16'(bus.out_valid), 16'h0);
    chk("mrst_f",   16'(bus.flags),     16'h8);
    chk("mrst_r",   16'(bus.result),    16'h0);
    chk("mrst_rdy", 16'(bus.in_ready),  16'h0);
    step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk("post_rdy", 16'(bus.in_ready), 16'h1);
    issue(4'h9, 8'h00, 8'h00, 3'd5);
    res("post_rd5", 8'h00, 4'b1000);
    issue(4'h0, 8'h02, 8'h03, 3'd0);
    res("post_add", 8'h05, 4'b0000);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
